// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: phase-state encodings,
// edge classification and the signed edge-accumulator type.
// No ports; imported by quad_decoder and debounce_filter.
package quad_decoder_pkg;

    // Signed accumulator, enough for +/-4 pending edges.
    localparam int ACC_W = 4;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Phase state is the filtered pair {A,B}; Gray-coded rotation order.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } phase_t;

    // Result of comparing the previous and current phase state.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_CW   = 2'd1,
        EDGE_CCW  = 2'd2,
        EDGE_ILL  = 2'd3
    } edge_t;

    // Accumulator increments for a clockwise / counter-clockwise edge.
    localparam acc_t STEP_CW  = 4'sd1;
    localparam acc_t STEP_CCW = -4'sd1;

    // Next phase in the clockwise direction: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic phase_t cw_next(input phase_t p);
        phase_t n;
        case (p)
            S00:     n = S01;
            S01:     n = S11;
            S11:     n = S10;
            default: n = S00;
        endcase
        return n;
    endfunction

    // Both bits changing at once cannot be attributed to a direction.
    function automatic edge_t classify(input phase_t prev, input phase_t cur);
        edge_t e;
        if (cur == prev)
            e = EDGE_NONE;
        else if (cur == cw_next(prev))
            e = EDGE_CW;
        else if (prev == cw_next(cur))
            e = EDGE_CCW;
        else
            e = EDGE_ILL;
        return e;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus run-length debouncer for one encoder channel.
// Ports: clk; arst (async clear of the run counter); load (sync load of raw
// into synchronizer and filtered value); raw (async input); filt (debounced).
module debounce_filter
    import quad_decoder_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic load,
    input  logic raw,
    output logic filt
);

    localparam int CNT_W = 4;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             take;

    // The filtered value flips on the DEBOUNCE-th consecutive mismatch.
    assign take = (sync2 != filt) && (cnt == CNT_W'(DEBOUNCE - 1));

    // Synchronizer and filtered value carry no reset: while held in reset
    // they track the raw pin so that release never looks like an edge.
    always_ff @(posedge clk) begin
        if (load) begin
            sync1 <= raw;
            sync2 <= raw;
            filt  <= raw;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (take)
                filt <= sync2;
        end
    end

    // Any cycle where the synchronized value matches clears the run.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            cnt <= '0;
        else if (sync2 == filt || take)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounces A/B, decodes phase edges, accumulates them
// and issues one-cycle UP/Down step requests to a 5-bit up/down counter.
// Ports: CLK, RST (async high); A, B raw encoder; High/Low counter limits;
// UP/Down step pulses; Dir last valid direction; Err illegal-transition pulse.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int DEBOUNCE       = 4,
    parameter int EDGES_PER_STEP = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    input  logic High,
    input  logic Low,
    output logic UP,
    output logic Down,
    output logic Dir,
    output logic Err
);

    localparam acc_t STEP_POS = acc_t'(EDGES_PER_STEP);
    localparam acc_t STEP_NEG = acc_t'(-EDGES_PER_STEP);

    logic   rst_a;      // async-asserted, sync-released reset for the datapath
    logic   rst_ld;     // identical copy, used only as a synchronous load qualifier
    logic   fa;
    logic   fb;
    phase_t ph;
    phase_t ph_cur;
    edge_t  edge_q;
    acc_t   acc;
    acc_t   acc_nxt;

    // Reset release is retimed by one flop, so the first state update
    // lands on the second rising edge after RST falls. Two copies keep
    // the async-reset net apart from the synchronous load net.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rst_a  <= 1'b1;
            rst_ld <= 1'b1;
        end else begin
            rst_a  <= 1'b0;
            rst_ld <= 1'b0;
        end
    end

    debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_a (
        .clk  (CLK),
        .arst (rst_a),
        .load (rst_ld),
        .raw  (A),
        .filt (fa)
    );

    debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_b (
        .clk  (CLK),
        .arst (rst_a),
        .load (rst_ld),
        .raw  (B),
        .filt (fb)
    );

    assign ph_cur = phase_t'({fa, fb});

    // Previous phase; follows the raw pins during reset like the filters.
    always_ff @(posedge CLK) begin
        if (rst_ld)
            ph <= phase_t'({A, B});
        else
            ph <= ph_cur;
    end

    // One classified transition per cycle, registered.
    always_ff @(posedge CLK or posedge rst_a) begin
        if (rst_a)
            edge_q <= EDGE_NONE;
        else
            edge_q <= classify(ph, ph_cur);
    end

    always_comb begin
        acc_nxt = acc;
        case (edge_q)
            EDGE_CW:  acc_nxt = acc + STEP_CW;
            EDGE_CCW: acc_nxt = acc + STEP_CCW;
            default:  acc_nxt = acc;
        endcase
    end

    // A completed step always clears the accumulator; the counter limit
    // only decides whether the request is actually issued.
    always_ff @(posedge CLK or posedge rst_a) begin
        if (rst_a) begin
            acc  <= '0;
            UP   <= 1'b0;
            Down <= 1'b0;
            Err  <= 1'b0;
            Dir  <= 1'b0;
        end else begin
            UP   <= 1'b0;
            Down <= 1'b0;
            Err  <= 1'b0;
            if (edge_q == EDGE_ILL) begin
                Err <= 1'b1;
            end else if (edge_q == EDGE_CW || edge_q == EDGE_CCW) begin
                Dir <= (edge_q == EDGE_CW);
                if (acc_nxt == STEP_POS) begin
                    acc <= '0;
                    UP  <= ~High;
                end else if (acc_nxt == STEP_NEG) begin
                    acc  <= '0;
                    Down <= ~Low;
                end else begin
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule
